grev_issue_ctrl: RTL and testbench

//   Issue/retire stage wrapped around the registered GREV permutation unit.

---
 rtl/grev_issue_ctrl_if.sv | 25 ++
 rtl/grev_issue_ctrl.sv | 102 ++++++++++
 tb/tb_grev_issue_ctrl.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/grev_issue_ctrl_if.sv
// Core-side request/result port of the GREV issue/retire stage.
// master = core, slave = grev_issue_ctrl.
interface grev_issue_ctrl_if #(
  parameter int TAG_W = 4
) ();
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_rs1;
  logic [31:0]      in_rs2;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_rd;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_rs1, in_rs2, in_tag, out_ready,
    input  in_ready, out_valid, out_rd, out_tag
  );

  modport slave (
    input  in_valid, in_rs1, in_rs2, in_tag, out_ready,
    output in_ready, out_valid, out_rd, out_tag
  );
endinterface

// File: rtl/grev_issue_ctrl.sv
// Issue/retire wrapper for the fixed-latency GREV unit: tag pipe, credit-gated issue, result FIFO.
// Optional GREV_ISSUE_STATS_EN adds stat_issued/stat_stall counters.
module grev_issue_ctrl #(
  parameter int GREV_LAT   = 1,
  parameter int FIFO_DEPTH = 3,
  parameter int TAG_W      = 4
) (
  input  logic              clock,
  input  logic              resetn,
  grev_issue_ctrl_if.slave  io,
  output logic [31:0]       grev_rs1,
  output logic [4:0]        grev_rs2,
  input  logic [31:0]       grev_rd
`ifdef GREV_ISSUE_STATS_EN
  ,
  output logic [31:0]       stat_issued,
  output logic [31:0]       stat_stall
`endif
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [31:0]      rd;
  } ent_t;

  logic [GREV_LAT-1:0]             vld_pipe;
  logic [GREV_LAT-1:0][TAG_W-1:0]  tag_pipe;
  ent_t                            mem [FIFO_DEPTH];
  logic [PW-1:0]                   wr_ptr, rd_ptr;
  logic [CW-1:0]                   count;
  logic                            accept, push, pop;
  int unsigned                     inflight;
  logic                            unused_rs2;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign grev_rs1   = io.in_rs1;
  assign grev_rs2   = io.in_rs2[4:0];
  assign unused_rs2 = ^io.in_rs2[31:5];

  always_comb begin
    inflight = 0;
    for (int i = 0; i < GREV_LAT; i++) inflight += {31'b0, vld_pipe[i]};
  end

  // Credits count only registered state, so a same-cycle pop never frees a slot.
  assign io.in_ready  = resetn && ((32'(count) + inflight) < 32'(FIFO_DEPTH));
  assign accept       = io.in_valid && io.in_ready;
  assign push         = vld_pipe[GREV_LAT-1];
  assign pop          = io.out_valid && io.out_ready;
  assign io.out_valid = (count != '0);
  assign io.out_rd    = io.out_valid ? mem[rd_ptr].rd  : '0;
  assign io.out_tag   = io.out_valid ? mem[rd_ptr].tag : '0;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      vld_pipe <= '0;
      tag_pipe <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      vld_pipe[0] <= accept;
      tag_pipe[0] <= io.in_tag;
      for (int i = 1; i < GREV_LAT; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        tag_pipe[i] <= tag_pipe[i-1];
      end
      if (push) wr_ptr <= nxt(wr_ptr);
      if (pop)  rd_ptr <= nxt(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  // Storage is not reset; out_rd/out_tag are masked by out_valid instead.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= '{tag: tag_pipe[GREV_LAT-1], rd: grev_rd};
  end

`ifdef GREV_ISSUE_STATS_EN
  always_ff @(posedge clock) begin
    if (!resetn) begin
      stat_issued <= '0;
      stat_stall  <= '0;
    end else begin
      if (accept)                       stat_issued <= stat_issued + 32'd1;
      if (io.in_valid && !io.in_ready)  stat_stall  <= stat_stall + 32'd1;
    end
  end
`endif

  a_no_overflow: assert property (@(posedge clock) disable iff (!resetn)
    !(push && !pop && count == CW'(FIFO_DEPTH)));
endmodule

// File: tb/tb_grev_issue_ctrl.sv
// Directed bench for grev_issue_ctrl with a behavioural registered GREV unit and result scoreboard.
module tb_grev_issue_ctrl;
  localparam int LAT = 1, DEPTH = 3, TW = 4;

  logic clock = 1'b0;
  logic resetn = 1'b0;
  always #5 clock = ~clock;

  grev_issue_ctrl_if #(.TAG_W(TW)) io ();
  logic [31:0] grev_rs1;
  logic [4:0]  grev_rs2;
  logic [31:0] grev_rd;
`ifdef GREV_ISSUE_STATS_EN
  logic [31:0] stat_issued, stat_stall;
`endif

  grev_issue_ctrl #(.GREV_LAT(LAT), .FIFO_DEPTH(DEPTH), .TAG_W(TW)) dut (
    .clock    (clock),
    .resetn   (resetn),
    .io       (io),
    .grev_rs1 (grev_rs1),
    .grev_rs2 (grev_rs2),
    .grev_rd  (grev_rd)
`ifdef GREV_ISSUE_STATS_EN
    ,
    .stat_issued (stat_issued),
    .stat_stall  (stat_stall)
`endif
  );

  function automatic logic [31:0] grev(input logic [31:0] x, input logic [4:0] k);
    logic [31:0] r;
    r = x;
    if (k[0]) r = ((r & 32'h55555555) << 1)  | ((r & 32'hAAAAAAAA) >> 1);
    if (k[1]) r = ((r & 32'h33333333) << 2)  | ((r & 32'hCCCCCCCC) >> 2);
    if (k[2]) r = ((r & 32'h0F0F0F0F) << 4)  | ((r & 32'hF0F0F0F0) >> 4);
    if (k[3]) r = ((r & 32'h00FF00FF) << 8)  | ((r & 32'hFF00FF00) >> 8);
    if (k[4]) r = ((r & 32'h0000FFFF) << 16) | ((r & 32'hFFFF0000) >> 16);
    return r;
  endfunction

  // Registered GREV unit: samples every edge, result GREV_LAT edges later.
  logic [31:0] upipe [LAT];
  always @(posedge clock) begin
    upipe[0] <= grev(grev_rs1, grev_rs2);
    for (int i = 1; i < LAT; i++) upipe[i] <= upipe[i-1];
  end
  assign grev_rd = upipe[LAT-1];

  int n_chk = 0, n_err = 0;
  int n_acc, n_stall, start_acc;
  logic [TW+31:0] exp_q [$];
  logic [TW+31:0] pop_q [$];
  logic           hold_v;
  logic [31:0]    hold_rd;
  logic [TW-1:0]  hold_tag;
  logic [TW+31:0] e;
  logic [31:0] t2_rs2 [3] = '{32'd31, 32'd7, 32'd16};
  logic [31:0] t2_exp [3] = '{32'h1E6A2C48, 32'h482C6A1E, 32'h56781234};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One cycle: sample handshakes before the posedge, score pops, then move to the next negedge.
  task automatic cyc();
    logic [TW+31:0] x;
    #1;
    if (io.in_valid && io.in_ready) begin
      exp_q.push_back({io.in_tag, grev(io.in_rs1, io.in_rs2[4:0])});
      n_acc++;
    end
    if (io.in_valid && !io.in_ready) n_stall++;
    if (hold_v) begin
      chk("hold_vld", 32'(io.out_valid), 32'd1);
      chk("hold_rd",  io.out_rd, hold_rd);
      chk("hold_tag", 32'(io.out_tag), 32'(hold_tag));
    end
    hold_v   = io.out_valid && !io.out_ready;
    hold_rd  = io.out_rd;
    hold_tag = io.out_tag;
    if (io.out_valid && io.out_ready) begin
      if (exp_q.size() == 0) chk("spurious_pop", 32'd1, 32'd0);
      else begin
        x = exp_q.pop_front();
        chk("sb_rd",  io.out_rd, x[31:0]);
        chk("sb_tag", 32'(io.out_tag), 32'(x[TW+31:32]));
        pop_q.push_back({io.out_tag, io.out_rd});
      end
    end
    chk("credit", 32'(exp_q.size() <= DEPTH), 32'd1);
    @(negedge clock);
  endtask

  task automatic apply_reset();
    resetn = 1'b0;
    io.in_valid = 1'b0;
    io.out_ready = 1'b0;
    #1 chk("rst_in_ready_low", 32'(io.in_ready), 32'd0);
    @(negedge clock);
    resetn = 1'b1;
    exp_q.delete();
    pop_q.delete();
    n_acc = 0;
    n_stall = 0;
    hold_v = 1'b0;
    #1;
    chk("rst_out_valid", 32'(io.out_valid), 32'd0);
    chk("rst_in_ready",  32'(io.in_ready), 32'd1);
    chk("rst_out_rd",    io.out_rd, 32'd0);
    chk("rst_out_tag",   32'(io.out_tag), 32'd0);
`ifdef GREV_ISSUE_STATS_EN
    chk("rst_stat_issued", stat_issued, 32'd0);
    chk("rst_stat_stall",  stat_stall, 32'd0);
`endif
  endtask

  initial begin
    io.in_valid = 1'b0; io.in_rs1 = '0; io.in_rs2 = '0; io.in_tag = '0; io.out_ready = 1'b0;
    hold_v = 1'b0; n_acc = 0; n_stall = 0;
    @(negedge clock);
    apply_reset();

    // single op, latency GREV_LAT+1
    io.in_valid = 1'b1; io.in_rs1 = 32'h12345678; io.in_rs2 = 32'd24; io.in_tag = 4'd5;
    cyc();
    io.in_valid = 1'b0;
    for (int k = 0; k < LAT; k++) begin
      #1 chk("t1_early_valid", 32'(io.out_valid), 32'd0);
      cyc();
    end
    #1;
    chk("t1_valid", 32'(io.out_valid), 32'd1);
    chk("t1_rd",    io.out_rd, 32'h78563412);
    chk("t1_tag",   32'(io.out_tag), 32'd5);
    io.out_ready = 1'b1;
    cyc();
    io.out_ready = 1'b0;

    // back-to-back with out_ready held
    pop_q.delete();
    io.out_ready = 1'b1; io.in_valid = 1'b1; io.in_rs1 = 32'h12345678;
    for (int i = 0; i < 3; i++) begin
      io.in_rs2 = t2_rs2[i];
      io.in_tag = TW'(i + 1);
      #1 chk("t2_in_ready", 32'(io.in_ready), 32'd1);
      cyc();
    end
    io.in_valid = 1'b0;
    for (int c = 0; c < 10 && pop_q.size() < 3; c++) cyc();
    chk("t2_count", 32'(pop_q.size()), 32'd3);
    for (int i = 0; i < 3 && i < pop_q.size(); i++) begin
      e = pop_q[i];
      chk("t2_rd",  e[31:0], t2_exp[i]);
      chk("t2_tag", 32'(e[TW+31:32]), 32'(i + 1));
    end
    io.out_ready = 1'b0;

    // back-pressure: out_ready low while streaming 5 ops
    apply_reset();
    io.in_valid = 1'b1;
    for (int c = 0; c < 8; c++) begin
      io.in_tag = TW'(n_acc); io.in_rs1 = 32'hCAFE0000 + 32'(n_acc); io.in_rs2 = 32'(n_acc * 5);
      cyc();
    end
    #1;
    chk("t3_accepted", 32'(n_acc), 32'(DEPTH));
    chk("t3_in_ready", 32'(io.in_ready), 32'd0);
    chk("t3_stalls",   32'(n_stall), 32'd5);
    io.out_ready = 1'b1;
    for (int c = 0; c < 40 && pop_q.size() < 5; c++) begin
      io.in_valid = (n_acc < 5);
      io.in_tag = TW'(n_acc); io.in_rs1 = 32'hCAFE0000 + 32'(n_acc); io.in_rs2 = 32'(n_acc * 5);
      cyc();
    end
    io.in_valid = 1'b0;
    chk("t3_count", 32'(pop_q.size()), 32'd5);
    for (int i = 0; i < 5 && i < pop_q.size(); i++) begin
      e = pop_q[i];
      chk("t3_tag_order", 32'(e[TW+31:32]), 32'(i));
    end
`ifdef GREV_ISSUE_STATS_EN
    chk("t6_stat_issued", stat_issued, 32'd5);
    chk("t6_stat_stall",  stat_stall, 32'(n_stall));
`endif

    // full FIFO, simultaneous push/pop and pointer wrap
    pop_q.delete();
    start_acc = n_acc;
    for (int c = 0; c < 80 && pop_q.size() < 10; c++) begin
      io.in_valid  = (n_acc - start_acc < 10);
      io.in_tag    = TW'(n_acc - start_acc);
      io.in_rs1    = 32'h9E3779B9 * 32'(n_acc - start_acc + 1);
      io.in_rs2    = 32'((n_acc - start_acc) * 7);
      io.out_ready = c[0];
      cyc();
    end
    io.in_valid = 1'b0; io.out_ready = 1'b0;
    chk("t4_count", 32'(pop_q.size()), 32'd10);
    for (int i = 0; i < 10 && i < pop_q.size(); i++) begin
      e = pop_q[i];
      chk("t4_tag_order", 32'(e[TW+31:32]), 32'(i));
    end

    // reset with ops buffered and in flight
    io.in_valid = 1'b1; start_acc = n_acc;
    for (int c = 0; c < 10 && n_acc - start_acc < 3; c++) begin
      io.in_tag = TW'(12 + n_acc - start_acc); io.in_rs1 = 32'hDEAD0000 + 32'(n_acc); io.in_rs2 = 32'd3;
      cyc();
    end
    chk("t5_preload", 32'(n_acc - start_acc), 32'd3);
    apply_reset();
    io.in_valid = 1'b1; io.in_rs1 = 32'h0F0F1234; io.in_rs2 = 32'd24; io.in_tag = 4'd9; io.out_ready = 1'b1;
    cyc();
    io.in_valid = 1'b0;
    for (int c = 0; c < 10 && pop_q.size() < 1; c++) cyc();
    chk("t5_count", 32'(pop_q.size()), 32'd1);
    if (pop_q.size() > 0) begin
      e = pop_q[0];
      chk("t5_rd",  e[31:0], 32'h34120F0F);
      chk("t5_tag", 32'(e[TW+31:32]), 32'd9);
    end
    #1 chk("t5_drained", 32'(io.out_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
